// File: rtl/sha256_digest_reader_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Constants and types shared by the SHA256 core's input-side writer and the
// digest reader.
//   DIGEST_W    : width of the finished digest
//   IN_WORD_W   : core input word width (writer side)
//   IN_MAX_LEN  : maximum core inLen value (writer side)
//   rd_state_t  : digest reader FSM states
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int DIGEST_W   = 256;
    localparam int IN_WORD_W  = 32;
    localparam int IN_MAX_LEN = 32;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    // Number of output beats needed to carry one digest at a given beat width.
    function automatic int beats_per_digest(input int out_w);
        return DIGEST_W / out_w;
    endfunction

endpackage

// File: rtl/sha256_digest_reader_if.sv
// -----------------------------------------------------------------------------
// sha256_digest_reader_if
// Valid/accept beat stream from the digest reader to the response path.
//   outData   : current beat, MSB-first slice of the digest
//   outValid  : beat valid
//   outAccept : downstream takes the beat when outValid && outAccept
//   outLast   : high with the final beat of a digest
// Modports: master (reader side), slave (consumer side).
// -----------------------------------------------------------------------------
interface sha256_digest_reader_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] outData;
    logic             outValid;
    logic             outAccept;
    logic             outLast;

    modport master (
        output outData,
        output outValid,
        output outLast,
        input  outAccept
    );

    modport slave (
        input  outData,
        input  outValid,
        input  outLast,
        output outAccept
    );
endinterface

// File: rtl/sha256_digest_reader.sv
// -----------------------------------------------------------------------------
// sha256_digest_reader
// Captures the SHA256 core's digest on the rising edge of its ready flag and
// streams it out MSB-first as DIGEST_W/OUT_W beats over a valid/accept stream.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   digest        : core digest, sampled only at capture
//   ready         : core done level; a rising edge marks a new digest
//   clear         : synchronous abort (back to idle, overrun cleared)
//   out_if        : beat stream (master modport)
//   busy          : a digest is held or being sent
//   overrun       : sticky, a digest arrived while busy and was dropped
// Optional feature macro SHA256_DIGEST_READER_COMPARE_EN adds
//   expDigest (in), matchValid (out), match (out): digest compare at capture.
// -----------------------------------------------------------------------------
module sha256_digest_reader
    import sha256_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DIGEST_W-1:0]         digest,
    input  logic                        ready,
    input  logic                        clear,
    sha256_digest_reader_if.master      out_if,
`ifdef SHA256_DIGEST_READER_COMPARE_EN
    input  logic [DIGEST_W-1:0]         expDigest,
    output logic                        matchValid,
    output logic                        match,
`endif
    output logic                        busy,
    output logic                        overrun
);

    localparam int BEATS = beats_per_digest(OUT_W);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    rd_state_t           state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overrun_q, overrun_d;
    logic                ready_q;

    logic                rise_s;
    logic                accept_s;
    logic                last_acc_s;
    logic                load_s;
    logic [DIGEST_W-1:0] shifted_s;

    assign rise_s     = ready && !ready_q;
    assign accept_s   = (state_q == RD_SEND) && out_if.outAccept;
    assign last_acc_s = accept_s && (count_q == LAST_CNT);
    assign shifted_s  = {shreg_q[DIGEST_W-OUT_W-1:0], {OUT_W{1'b0}}};

    // Outputs decode straight from registers; shreg is zeroed whenever the
    // stream is abandoned or completes, so outData is 0 while idle.
    assign out_if.outValid = (state_q == RD_SEND);
    assign out_if.outData  = shreg_q[DIGEST_W-1 -: OUT_W];
    assign out_if.outLast  = (state_q == RD_SEND) && (count_q == LAST_CNT);
    assign busy            = (state_q == RD_SEND);
    assign overrun         = overrun_q;

    // State, shift register, beat counter, overrun flag and ready edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q   <= 1'b1;  // a ready level high out of reset is not a rise
            state_q   <= RD_IDLE;
            shreg_q   <= {DIGEST_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            ready_q   <= ready;  // tracks ready even while clear is asserted
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: clear dominates, then capture / shift / overrun.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        load_s    = 1'b0;
        if (clear) begin
            state_d   = RD_IDLE;
            shreg_d   = {DIGEST_W{1'b0}};
            count_d   = {CNT_W{1'b0}};
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (rise_s) begin
                        load_s  = 1'b1;
                        shreg_d = digest;
                        count_d = {CNT_W{1'b0}};
                        state_d = RD_SEND;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
                RD_SEND: begin
                    if (last_acc_s) begin
                        // A rise coinciding with the final accept starts the
                        // next digest with no idle bubble and no overrun.
                        if (rise_s) begin
                            load_s  = 1'b1;
                            shreg_d = digest;
                            count_d = {CNT_W{1'b0}};
                            state_d = RD_SEND;
                        end else begin
                            shreg_d = shifted_s;
                            count_d = {CNT_W{1'b0}};
                            state_d = RD_IDLE;
                        end
                    end else begin
                        if (accept_s) begin
                            shreg_d = shifted_s;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            shreg_d = shreg_q;
                        end
                        if (rise_s) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_q;
                        end
                    end
                end
                default: begin
                    state_d = RD_IDLE;
                end
            endcase
        end
    end

`ifdef SHA256_DIGEST_READER_COMPARE_EN
    logic match_valid_q, match_valid_d;
    logic match_q, match_d;

    assign matchValid = match_valid_q;
    assign match      = match_q;

    // Compare result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
        end else begin
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
        end
    end

    // The compare result is taken at every capture and held until the next.
    always_comb begin
        match_valid_d = match_valid_q;
        match_d       = match_q;
        if (clear) begin
            match_valid_d = 1'b0;
            match_d       = 1'b0;
        end else if (load_s) begin
            match_valid_d = 1'b1;
            match_d       = (digest == expDigest);
        end else begin
            match_valid_d = match_valid_q;
            match_d       = match_q;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_digest_reader.sv
// -----------------------------------------------------------------------------
// tb_sha256_digest_reader
// Scoreboard bench for sha256_digest_reader at OUT_W = 8. Expected beats are
// queued when a digest is presented and compared as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_sha256_digest_reader;

    localparam int OUT_W = 8;
    localparam int BEATS = 32;
    localparam logic [255:0] D1 =
        256'h339ae409_5b1c0e7a_11223344_55667788_99aabbcc_ddeeff00_0f1e2d3c_4bdd2689;
    localparam logic [255:0] D2 =
        256'hc0ffee01_02030405_06070809_0a0b0c0d_0e0f1011_12131415_16171819_1a1b1c1d;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] digest;
    logic         ready;
    logic         clear;
    logic         busy;
    logic         overrun;
`ifdef SHA256_DIGEST_READER_COMPARE_EN
    logic [255:0] exp_digest;
    logic         match_valid;
    logic         match;
`endif

    sha256_digest_reader_if #(.OUT_W(OUT_W)) out_if ();

    sha256_digest_reader #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .digest    (digest),
        .ready     (ready),
        .clear     (clear),
        .out_if    (out_if),
`ifdef SHA256_DIGEST_READER_COMPARE_EN
        .expDigest (exp_digest),
        .matchValid(match_valid),
        .match     (match),
`endif
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    logic [8:0] sb_q[$];   // {last, data}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_digest(input logic [255:0] d);
        for (int i = 0; i < BEATS; i++) begin
            sb_q.push_back({(i == BEATS - 1), d[255 - 8*i -: 8]});
        end
    endtask

    // Present a digest with a ready rise; returns just after the capture edge.
    task automatic start(input logic [255:0] d);
        digest = d;
        ready  = 1'b1;
        push_digest(d);
        tick();
        ready  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int cyc);
        cyc = 0;
        while (busy && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: compares accepted beats against the scoreboard and checks that
    // a stalled beat holds steady into the next cycle.
    logic       held_v = 1'b0;
    logic [8:0] held   = 9'd0;
    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (held_v && out_if.outValid) begin
            check("stall_hold", 64'({out_if.outLast, out_if.outData}), 64'(held));
        end
        held_v = out_if.outValid && !out_if.outAccept;
        held   = {out_if.outLast, out_if.outData};
        if (out_if.outValid && out_if.outAccept) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_beat = sb_q.pop_front();
                check("beat", 64'({out_if.outLast, out_if.outData}), 64'(exp_beat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        ready   = 1'b0;
        clear   = 1'b0;
        digest  = 256'd0;
        out_if.outAccept = 1'b0;
`ifdef SHA256_DIGEST_READER_COMPARE_EN
        exp_digest = 256'd0;
`endif
        repeat (2) tick();
        check("rst_valid",   64'(out_if.outValid), 64'd0);
        check("rst_last",    64'(out_if.outLast),  64'd0);
        check("rst_data",    64'(out_if.outData),  64'd0);
        check("rst_busy",    64'(busy),            64'd0);
        check("rst_overrun", 64'(overrun),         64'd0);
        reset_n = 1'b1;
        tick();

        // Basic stream under continuous accept.
        out_if.outAccept = 1'b1;
        start(D1);
        check("lat_valid", 64'(out_if.outValid), 64'd1);
        check("beat0",     64'(out_if.outData),  64'h33);
        wait_idle(100, cyc);
        check("basic_cycles", 64'(cyc), 64'd32);
        check("basic_drain",  64'(sb_q.size()), 64'd0);

        // Backpressure: accept alternates, stalls first.
        tick();
        out_if.outAccept = 1'b1;
        start(D1);
        cyc = 0;
        while (busy && cyc < 200) begin
            out_if.outAccept = ~out_if.outAccept;
            tick();
            cyc++;
        end
        check("bp_cycles", 64'(cyc), 64'd64);
        check("bp_drain",  64'(sb_q.size()), 64'd0);
        out_if.outAccept = 1'b1;

        // Overrun: second rise at beat 10 is dropped.
        tick();
        start(D1);
        repeat (10) tick();
        digest = D2;
        ready  = 1'b1;
        tick();
        ready  = 1'b0;
        check("ovr_set",  64'(overrun), 64'd1);
        check("ovr_busy", 64'(busy),    64'd1);
        wait_idle(100, cyc);
        check("ovr_sticky", 64'(overrun), 64'd1);
        check("ovr_drain",  64'(sb_q.size()), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'd0);

        // Back-to-back: rise coincides with the last accept.
        start(D1);
        repeat (31) tick();
        digest = D2;
        ready  = 1'b1;
        push_digest(D2);
        tick();
        ready  = 1'b0;
        check("b2b_busy",    64'(busy),             64'd1);
        check("b2b_valid",   64'(out_if.outValid),  64'd1);
        check("b2b_byte0",   64'(out_if.outData),   64'hc0);
        check("b2b_overrun", 64'(overrun),          64'd0);
        wait_idle(100, cyc);
        check("b2b_drain", 64'(sb_q.size()), 64'd0);

        // Clear at beat 5 with overrun set and a simultaneous rise.
        tick();
        start(D1);
        repeat (2) tick();
        digest = D2;
        ready  = 1'b1;
        tick();
        ready  = 1'b0;
        check("clr_pre_overrun", 64'(overrun), 64'd1);
        repeat (2) tick();
        clear = 1'b1;
        out_if.outAccept = 1'b0;
        ready = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid",   64'(out_if.outValid), 64'd0);
        check("clr_busy",    64'(busy),            64'd0);
        check("clr_overrun", 64'(overrun),         64'd0);
        tick();
        check("clr_rise_discarded", 64'(busy), 64'd0);
        ready = 1'b0;
        out_if.outAccept = 1'b1;
        sb_q.delete();
        tick();

        // Reset mid-stream at beat 20, ready held high through release.
        start(D1);
        repeat (20) tick();
        digest  = D2;
        ready   = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mrst_valid",   64'(out_if.outValid), 64'd0);
        check("mrst_data",    64'(out_if.outData),  64'd0);
        check("mrst_last",    64'(out_if.outLast),  64'd0);
        check("mrst_busy",    64'(busy),            64'd0);
        check("mrst_overrun", 64'(overrun),         64'd0);
        sb_q.delete();
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("mrst_no_capture", 64'(busy),            64'd0);
        check("mrst_no_valid",   64'(out_if.outValid), 64'd0);
        ready = 1'b0;
        tick();

`ifdef SHA256_DIGEST_READER_COMPARE_EN
        // Compare: equal digest, then one bit flipped, then clear.
        exp_digest = D1;
        start(D1);
        check("cmp_valid_eq", 64'(match_valid), 64'd1);
        check("cmp_match_eq", 64'(match),       64'd1);
        wait_idle(100, cyc);
        exp_digest = D1 ^ (256'd1 << 77);
        tick();
        start(D1);
        check("cmp_valid_ne", 64'(match_valid), 64'd1);
        check("cmp_match_ne", 64'(match),       64'd0);
        wait_idle(100, cyc);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("cmp_clear", 64'(match_valid), 64'd0);
`endif

        check("final_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
